// File: rtl/controle_cofre.sv
// Keypad lock sequencer: checks entered digits against a programmable code,
// counts wrong digits per attempt, enforces a timed lockout and lets the user reprogram the code.
module controle_cofre #(
  parameter int          NUM_DIGITOS     = 6,
  parameter int          MAX_ERROS       = 2,
  parameter int          BLOQUEIO_CICLOS = 16,
  parameter logic [31:0] CODIGO_PADRAO   = 32'h00590981
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere,
  input  logic [3:0] numero,
  input  logic       programa,
  input  logic       travar,
  output logic       LED,
  output logic       aberto,
  output logic       bloqueado,
  output logic [1:0] estado_out,
  output logic [2:0] indice,
  output logic [1:0] erros
);

  localparam int         CW        = 4 * NUM_DIGITOS;
  localparam logic [2:0] ULTIMO    = 3'(NUM_DIGITOS - 1);
  localparam logic [1:0] ERROS_MAX = 2'(MAX_ERROS);
  localparam logic [15:0] TIMER_INI = 16'(BLOQUEIO_CICLOS - 1);

  typedef enum logic [1:0] {
    ENTRADA  = 2'b00,
    ABERTO   = 2'b01,
    PROGRAMA = 2'b10,
    BLOQUEIO = 2'b11
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [2:0]     indice_q, indice_d;
  logic [1:0]     erros_q, erros_d;
  logic           led_q, led_d;
  logic [15:0]    timer_q, timer_d;
  logic [CW-1:0]  codigo_q, codigo_d;
  logic [CW-1:0]  shadow_q, shadow_d;
  logic [CW-1:0]  shadow_w;
  logic [1:0]     erros_inc;
  logic           aberto_q, bloqueado_q;

  // First digit lives in the most significant nibble of the packed code.
  function automatic logic [3:0] digito(input logic [CW-1:0] v, input logic [2:0] k);
    return v[4*(NUM_DIGITOS-1-int'(k)) +: 4];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q    <= ENTRADA;
      indice_q    <= 3'd0;
      erros_q     <= 2'd0;
      led_q       <= 1'b0;
      timer_q     <= 16'd0;
      codigo_q    <= CODIGO_PADRAO[CW-1:0];
      shadow_q    <= '0;
      aberto_q    <= 1'b0;
      bloqueado_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      indice_q    <= indice_d;
      erros_q     <= erros_d;
      led_q       <= led_d;
      timer_q     <= timer_d;
      codigo_q    <= codigo_d;
      shadow_q    <= shadow_d;
      aberto_q    <= (estado_d == ABERTO);
      bloqueado_q <= (estado_d == BLOQUEIO);
    end
  end

  always_comb begin
    estado_d  = estado_q;
    indice_d  = indice_q;
    erros_d   = erros_q;
    led_d     = led_q;
    timer_d   = timer_q;
    codigo_d  = codigo_q;
    shadow_d  = shadow_q;
    erros_inc = erros_q + 2'd1;
    shadow_w  = shadow_q;
    shadow_w[4*(NUM_DIGITOS-1-int'(indice_q)) +: 4] = numero;

    case (estado_q)
      ENTRADA: begin
        if (insere) begin
          if (numero == digito(codigo_q, indice_q)) begin
            if (indice_q == ULTIMO) begin
              estado_d = ABERTO;
              indice_d = 3'd0;
              erros_d  = 2'd0;
            end else begin
              indice_d = indice_q + 3'd1;
            end
          end else begin
            erros_d = erros_inc;
            led_d   = 1'b1;
            if (erros_inc == ERROS_MAX) begin
              estado_d = BLOQUEIO;
              timer_d  = TIMER_INI;
              indice_d = 3'd0;
            end else begin
              estado_d = ENTRADA;
            end
          end
        end else begin
          estado_d = ENTRADA;
        end
      end

      BLOQUEIO: begin
        if (timer_q == 16'd0) begin
          estado_d = ENTRADA;
          erros_d  = 2'd0;
          led_d    = 1'b0;
          indice_d = 3'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      ABERTO: begin
        if (travar) begin
          estado_d = ENTRADA;
          led_d    = 1'b0;
          erros_d  = 2'd0;
          indice_d = 3'd0;
        end else if (programa) begin
          estado_d = PROGRAMA;
          indice_d = 3'd0;
          shadow_d = '0;
        end else begin
          estado_d = ABERTO;
        end
      end

      PROGRAMA: begin
        // Abort wins over a digit arriving in the same cycle.
        if (travar) begin
          estado_d = ABERTO;
          indice_d = 3'd0;
          led_d    = 1'b0;
          shadow_d = '0;
        end else if (insere) begin
          if (numero <= 4'd9) begin
            if (indice_q == ULTIMO) begin
              codigo_d = shadow_w;
              shadow_d = '0;
              estado_d = ABERTO;
              indice_d = 3'd0;
              led_d    = 1'b0;
            end else begin
              shadow_d = shadow_w;
              indice_d = indice_q + 3'd1;
            end
          end else begin
            led_d = 1'b1;
          end
        end else begin
          estado_d = PROGRAMA;
        end
      end

      default: begin
        estado_d = ENTRADA;
        indice_d = 3'd0;
        erros_d  = 2'd0;
      end
    endcase
  end

  assign LED        = led_q;
  assign aberto     = aberto_q;
  assign bloqueado  = bloqueado_q;
  assign estado_out = estado_q;
  assign indice     = indice_q;
  assign erros      = erros_q;

endmodule
